// File: rtl/spk_sched_pkg.sv
// Shared encodings for the spike/status UART frame scheduler.
// Holds state codes, frame tag bytes and default marker bytes.
package spk_sched_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE = 4'd0;
  localparam state_t S_ARB  = 4'd1;
  localparam state_t S_H0   = 4'd2;
  localparam state_t S_H1   = 4'd3;
  localparam state_t S_TAG  = 4'd4;
  localparam state_t S_RD   = 4'd5;
  localparam state_t S_PAY  = 4'd6;
  localparam state_t S_CHK  = 4'd7;
  localparam state_t S_T0   = 4'd8;
  localparam state_t S_T1   = 4'd9;
  localparam state_t S_ACK  = 4'd10;

  localparam logic [7:0] TAG_SPK    = 8'h01;
  localparam logic [7:0] TAG_ST     = 8'h02;
  localparam logic [7:0] MARK_A_DEF = 8'hFA;
  localparam logic [7:0] MARK_B_DEF = 8'hF1;

endpackage

// File: rtl/spk_sched_rr_arb2.sv
// Two-way round-robin arbiter (spike vs status) for the UART frame scheduler.
// The last-served flag only moves when a frame is acknowledged.
module spk_sched_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic spk_req,
  input  logic st_req,
  input  logic upd,
  input  logic served_st,
  output logic gnt_st
);

  logic last_st;

  // Starting as "status served last" makes spike win the first tie.
  always_ff @(posedge clk) begin
    if (rst)
      last_st <= 1'b1;
    else if (upd)
      last_st <= served_st;
  end

  assign gnt_st = st_req & (~spk_req | ~last_st);

endmodule

// File: rtl/spike_uart_sched.sv
// Frame scheduler sharing one UART byte transmitter between spike-dump and status requesters.
// Optional checksum byte enabled by defining SPK_SCHED_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for any request
// ARB   | pick requester, latch base/word
// H0/H1 | send MARK_A, MARK_B
// TAG   | send frame tag
// RD    | spike only: BRAM read bubble
// PAY   | send one payload byte
// CHK   | send XOR checksum (optional)
// T0/T1 | send MARK_B, MARK_A
// ACK   | pulse ack of the served requester
module spike_uart_sched
  import spk_sched_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter int         FRAME_LEN = 128,
  parameter logic [7:0] MARK_A    = MARK_A_DEF,
  parameter logic [7:0] MARK_B    = MARK_B_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spk_req,
  input  logic [ADDR_W-1:0] spk_base,
  output logic              spk_ack,
  input  logic              st_req,
  input  logic [31:0]       st_word,
  output logic              st_ack,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_SPK = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_ST  = ADDR_W'(3);
`ifdef SPK_SCHED_CHECKSUM_EN
  localparam state_t S_PAY_DONE = S_CHK;
`else
  localparam state_t S_PAY_DONE = S_T0;
`endif

  state_t            state, state_nx;
  logic              sel_st;
  logic              gnt_st;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       word_q;
  logic [7:0]        pay_q;
  logic              pay_hold;
  logic              accept;
  logic              last_byte;
  logic [7:0]        tag_byte;
  logic [7:0]        st_byte;
`ifdef SPK_SCHED_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

  spk_sched_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .spk_req   (spk_req),
    .st_req    (st_req),
    .upd       (state == S_ACK),
    .served_st (sel_st),
    .gnt_st    (gnt_st)
  );

  assign accept    = tx_valid & tx_ready;
  assign last_byte = sel_st ? (idx == LAST_ST) : (idx == LAST_SPK);
  assign tag_byte  = sel_st ? TAG_ST : TAG_SPK;
  // Address is held through RD and PAY so ram_data stays put while the byte waits.
  assign ram_addr  = base_q + idx;

  always_comb begin
    case (idx[1:0])
      2'd0:    st_byte = word_q[31:24];
      2'd1:    st_byte = word_q[23:16];
      2'd2:    st_byte = word_q[15:8];
      default: st_byte = word_q[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (spk_req | st_req) state_nx = S_ARB;
      S_ARB:  state_nx = (spk_req | st_req) ? S_H0 : S_IDLE;
      S_H0:   if (accept) state_nx = S_H1;
      S_H1:   if (accept) state_nx = S_TAG;
      S_TAG:  if (accept) state_nx = sel_st ? S_PAY : S_RD;
      S_RD:   state_nx = S_PAY;
      S_PAY:
        if (accept) begin
          if (last_byte)
            state_nx = S_PAY_DONE;
          else
            state_nx = sel_st ? S_PAY : S_RD;
        end
`ifdef SPK_SCHED_CHECKSUM_EN
      S_CHK:  if (accept) state_nx = S_T0;
`endif
      S_T0:   if (accept) state_nx = S_T1;
      S_T1:   if (accept) state_nx = S_ACK;
      S_ACK:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    spk_ack  = 1'b0;
    st_ack   = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_H0:  begin tx_valid = 1'b1; tx_data = MARK_A;   end
      S_H1:  begin tx_valid = 1'b1; tx_data = MARK_B;   end
      S_TAG: begin tx_valid = 1'b1; tx_data = tag_byte; end
      S_PAY: begin
        tx_valid = 1'b1;
        tx_data  = sel_st ? st_byte : (pay_hold ? pay_q : ram_data);
      end
`ifdef SPK_SCHED_CHECKSUM_EN
      S_CHK: begin tx_valid = 1'b1; tx_data = chk_q;    end
`endif
      S_T0:  begin tx_valid = 1'b1; tx_data = MARK_B;   end
      S_T1:  begin tx_valid = 1'b1; tx_data = MARK_A;   end
      S_ACK: begin spk_ack = ~sel_st; st_ack = sel_st;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_st   <= 1'b0;
      base_q   <= '0;
      word_q   <= '0;
      idx      <= '0;
      pay_q    <= '0;
      pay_hold <= 1'b0;
`ifdef SPK_SCHED_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      if (state == S_ARB) begin
        sel_st <= gnt_st;
        base_q <= spk_base;
        word_q <= st_word;
        idx    <= '0;
      end
      if (state == S_PAY && accept)
        idx <= idx + 1'b1;
      // First PAY cycle forwards ram_data and captures it; later cycles replay the copy.
      if (state == S_PAY && !pay_hold)
        pay_q <= ram_data;
      pay_hold <= (state == S_PAY) && !accept && !sel_st;
`ifdef SPK_SCHED_CHECKSUM_EN
      if (state == S_TAG)
        chk_q <= tag_byte;
      else if (state == S_PAY && accept)
        chk_q <= chk_q ^ tx_data;
`endif
    end
  end

endmodule

// File: tb/tb_spike_uart_sched.sv
// Directed self-checking bench for spike_uart_sched (ADDR_W=10, FRAME_LEN=128).
// Honours SPK_SCHED_CHECKSUM_EN when building expected frames.
module tb_spike_uart_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       spk_req;
  logic [9:0] spk_base;
  logic       spk_ack;
  logic       st_req;
  logic [31:0] st_word;
  logic       st_ack;
  logic [9:0] ram_addr;
  logic [7:0] ram_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];
  logic [7:0] exp[$];
  int  n_spk, n_st, ack_cyc, last_acc;
  bit  saw_wrap;

  spike_uart_sched #(.ADDR_W(10), .FRAME_LEN(128)) dut (
    .clk(clk), .rst(rst),
    .spk_req(spk_req), .spk_base(spk_base), .spk_ack(spk_ack),
    .st_req(st_req), .st_word(st_word), .st_ack(st_ack),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // BRAM model: RAM[a] = a[7:0], one cycle read latency
  always @(posedge clk) ram_data <= ram_addr[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic build_spk(input logic [9:0] base);
    logic [7:0] x;
    exp.delete();
    exp.push_back(8'hFA); exp.push_back(8'hF1); exp.push_back(8'h01);
    x = 8'h01;
    for (int i = 0; i < 128; i++) begin
      logic [9:0] a;
      a = base + 10'(i);
      exp.push_back(a[7:0]);
      x = x ^ a[7:0];
    end
`ifdef SPK_SCHED_CHECKSUM_EN
    exp.push_back(x);
`endif
    exp.push_back(8'hF1); exp.push_back(8'hFA);
  endtask

  task automatic build_st(input logic [31:0] w);
    exp.delete();
    exp.push_back(8'hFA); exp.push_back(8'hF1); exp.push_back(8'h02);
    exp.push_back(w[31:24]); exp.push_back(w[23:16]);
    exp.push_back(w[15:8]);  exp.push_back(w[7:0]);
`ifdef SPK_SCHED_CHECKSUM_EN
    exp.push_back(8'h02 ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
    exp.push_back(8'hF1); exp.push_back(8'hFA);
  endtask

  // Collect accepted bytes until an ack is seen (or the cycle budget runs out).
  task automatic run_frame(input int bp, input bit drop_spk, input bit drop_st, input int max_cyc);
    bit hold_prev;
    logic [7:0] data_prev;
    logic [9:0] addr_prev;
    int cyc;
    got.delete();
    n_spk = 0; n_st = 0; ack_cyc = -1; last_acc = -1; saw_wrap = 0;
    hold_prev = 0; data_prev = 8'h00; addr_prev = ram_addr; cyc = 0;
    while (cyc < max_cyc && ack_cyc < 0) begin
      @(negedge clk);
      if (hold_prev) chk("hold_stable", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, data_prev});
      if (spk_ack) n_spk++;
      if (st_ack) n_st++;
      if (spk_ack || st_ack) begin
        ack_cyc = cyc;
        if (drop_spk) spk_req = 1'b0;
        if (drop_st)  st_req  = 1'b0;
      end
      if (addr_prev == 10'h3FF && ram_addr == 10'h000) saw_wrap = 1;
      addr_prev = ram_addr;
      tx_ready = (bp == 0) ? 1'b1 : (cyc % 3 == 0);
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        last_acc = cyc;
      end
      hold_prev = tx_valid && !tx_ready;
      data_prev = tx_data;
      cyc++;
    end
    chk("ack_seen", (ack_cyc >= 0), 1);
  endtask

  task automatic cmp_frame(input string tag);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk({tag, "_byte"}, got[i], exp[i]);
  endtask

  initial begin
    bit hit;
    int acc;
    rst = 1'b1; spk_req = 1'b0; st_req = 1'b0; spk_base = 10'h000;
    st_word = 32'h0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data",  tx_data, 0);
    chk("rst_busy",     busy, 0);
    chk("rst_acks",     {spk_ack, st_ack}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    rst = 1'b0;

    // Spike only, base 0x3F0: payload wraps through 0x3FF -> 0x000
    spk_base = 10'h3F0; spk_req = 1'b1;
    build_spk(10'h3F0);
    run_frame(0, 1, 0, 2000);
    cmp_frame("spk");
    chk("spk_ack_cnt", n_spk, 1);
    chk("spk_no_st_ack", n_st, 0);
    chk("spk_addr_wrap", saw_wrap, 1);
    chk("spk_ack_lat", ack_cyc - last_acc, 1);
    @(negedge clk);
    chk("spk_busy_after", busy, 0);

    // Status only
    st_word = 32'hDEADBEEF; st_req = 1'b1;
    build_st(32'hDEADBEEF);
    run_frame(0, 0, 1, 500);
    cmp_frame("st");
    chk("st_ack_cnt", n_st, 1);
    chk("st_no_spk_ack", n_spk, 0);
    chk("st_ack_lat", ack_cyc - last_acc, 1);
    @(negedge clk);
    chk("st_busy_after", busy, 0);

    // Both held high from reset: spike, status, spike
    rst = 1'b1; spk_req = 1'b1; st_req = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    build_spk(10'h3F0);
    run_frame(0, 0, 0, 2000);
    cmp_frame("rr1");
    chk("rr1_acks", {n_spk[7:0], n_st[7:0]}, {8'd1, 8'd0});
    build_st(32'hDEADBEEF);
    run_frame(0, 0, 0, 500);
    cmp_frame("rr2");
    chk("rr2_acks", {n_spk[7:0], n_st[7:0]}, {8'd0, 8'd1});
    build_spk(10'h3F0);
    run_frame(0, 1, 1, 2000);
    cmp_frame("rr3");
    chk("rr3_acks", {n_spk[7:0], n_st[7:0]}, {8'd1, 8'd0});
    @(negedge clk);
    chk("rr_busy_after", busy, 0);

    // Backpressure: tx_ready high one cycle in three
    spk_base = 10'h010; spk_req = 1'b1;
    build_spk(10'h010);
    run_frame(1, 1, 0, 3000);
    cmp_frame("bp_spk");
    chk("bp_spk_ack_cnt", n_spk, 1);
    st_req = 1'b1; st_word = 32'h1234A5C3;
    build_st(32'h1234A5C3);
    run_frame(1, 0, 1, 500);
    cmp_frame("bp_st");
    chk("bp_st_ack_cnt", n_st, 1);

    // Reset while the 10th spike payload byte is on the bus
    spk_base = 10'h000; spk_req = 1'b1; tx_ready = 1'b1;
    hit = 0; acc = 0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      if (tx_valid && acc == 12) begin
        chk("rst10_byte", tx_data, 8'h09);
        rst = 1'b1; spk_req = 1'b0; hit = 1;
      end else if (tx_valid) acc++;
    end
    chk("rst10_hit", hit, 1);
    @(negedge clk);
    chk("rst10_tx_valid", tx_valid, 0);
    chk("rst10_busy", busy, 0);
    chk("rst10_acks", {spk_ack, st_ack}, 0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst10_no_ack", {spk_ack, st_ack, busy}, 0);
    end
    spk_req = 1'b1;
    build_spk(10'h000);
    run_frame(0, 1, 0, 2000);
    cmp_frame("rst10_restart");
    chk("rst10_restart_ack", n_spk, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
